// File: rtl/chain_code_encoder.sv
// Freeman 8-direction chain-code encoder: raster-scans a constant binary image for the
// first object pixel, then traces its outer boundary clockwise, one code per move.
module chain_code_encoder #(
   parameter int IMG_W     = 16,
   parameter int IMG_H     = 16,
   parameter int MAX_CODES = 256,
   // word y bit x = pixel(x,y), 1 = object
   parameter logic [IMG_H-1:0][IMG_W-1:0] IMAGE = '0,
   localparam int XW = $clog2(IMG_W),
   localparam int YW = $clog2(IMG_H),
   localparam int CW = $clog2(MAX_CODES+1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          found,
   output logic          overflow,
   output logic [XW-1:0] start_x,
   output logic [YW-1:0] start_y,
   output logic [2:0]    code,
   output logic          code_valid,
   output logic [CW-1:0] code_count
);

   typedef enum logic [1:0] {IDLE, SCAN, TRACE, DONE} state_t;
   state_t state, state_nx;

   logic [XW-1:0] cx, nx;
   logic [YW-1:0] cy, ny;
   logic [2:0]    td, tries, first_code;
   logic          xinc, xdec, yinc, ydec, oob, nbr;
   logic          scan_hit, scan_end, stop, emit, last;

   // neighbour of the current pixel in the direction under test
   always_comb begin
      xinc = (td == 3'd0) || (td == 3'd1) || (td == 3'd7);
      xdec = (td == 3'd3) || (td == 3'd4) || (td == 3'd5);
      ydec = (td == 3'd1) || (td == 3'd2) || (td == 3'd3);
      yinc = (td == 3'd5) || (td == 3'd6) || (td == 3'd7);
      oob  = (xinc && cx == XW'(IMG_W-1)) || (xdec && cx == '0) ||
             (yinc && cy == YW'(IMG_H-1)) || (ydec && cy == '0);
      nx   = xinc ? cx + 1'b1 : (xdec ? cx - 1'b1 : cx);
      ny   = yinc ? cy + 1'b1 : (ydec ? cy - 1'b1 : cy);
      nbr  = !oob && IMAGE[ny][nx];
   end

   assign scan_hit = (state == SCAN) && IMAGE[cy][cx];
   assign scan_end = (cx == XW'(IMG_W-1)) && (cy == YW'(IMG_H-1));
   // back at the start pixel about to repeat the first move: contour closed
   assign stop = (state == TRACE) && nbr && (cx == start_x) && (cy == start_y) &&
                 (code_count != '0) && (td == first_code);
   assign emit = (state == TRACE) && nbr && !stop;
   assign last = emit && (code_count == CW'(MAX_CODES-1));

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = SCAN;
         SCAN:  if (scan_hit) state_nx = TRACE;
                else if (scan_end) state_nx = DONE;
         TRACE: if (stop || last || (!nbr && tries == 3'd7)) state_nx = DONE;
         DONE:  if (!start) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state == SCAN) || (state == TRACE);
      done       = (state == DONE);
      code_valid = emit;
      code       = emit ? td : 3'd0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cx <= '0; cy <= '0; td <= '0; tries <= '0; first_code <= '0;
         found <= 1'b0; overflow <= 1'b0; start_x <= '0; start_y <= '0;
         code_count <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               found <= 1'b0; overflow <= 1'b0; code_count <= '0;
               cx <= '0; cy <= '0;
            end
            SCAN: if (IMAGE[cy][cx]) begin
               // entering with d=7, so the first candidate is (7+2)%8
               start_x <= cx; start_y <= cy; found <= 1'b1;
               td <= 3'd1; tries <= '0;
            end else if (cx == XW'(IMG_W-1)) begin
               cx <= '0; cy <= cy + 1'b1;
            end else begin
               cx <= cx + 1'b1;
            end
            TRACE: if (emit) begin
               cx <= nx; cy <= ny;
               td <= td[0] ? td + 3'd2 : td + 3'd1;
               tries <= '0;
               code_count <= code_count + 1'b1;
               if (code_count == '0) first_code <= td;
               if (last) overflow <= 1'b1;
            end else if (!nbr) begin
               td <= td - 3'd1;
               tries <= tries + 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chain_code_encoder.sv
// Scoreboard bench: five encoder instances with different images; stimulus pushes the
// expected codes, a negedge monitor pops and compares on every code_valid.
module tb_chain_code_encoder;

   localparam int N = 5;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start_v [N];
   logic busy [N], done [N], found [N], ovf [N], cv [N];
   logic [3:0] sx [N], sy [N];
   logic [2:0] code [N];
   logic [8:0] cc [N];

   logic [2:0] expq [$];
   int sel = 0;
   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   // 0 empty, 1 single pixel (5,7), 2/4 2x2 square at (3,2), 3 pixels (0..2,0)
   function automatic logic [15:0][15:0] img_of(input int g);
      logic [15:0][15:0] m;
      m = '0;
      case (g)
         1: m[7][5] = 1'b1;
         2, 4: begin m[2][3] = 1'b1; m[2][4] = 1'b1; m[3][3] = 1'b1; m[3][4] = 1'b1; end
         3: begin m[0][0] = 1'b1; m[0][1] = 1'b1; m[0][2] = 1'b1; end
         default: ;
      endcase
      return m;
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int MC  = (g == 4) ? 2 : 256;
      localparam int CWL = $clog2(MC+1);
      logic [CWL-1:0] ccl;
      chain_code_encoder #(.IMG_W(16), .IMG_H(16), .MAX_CODES(MC), .IMAGE(img_of(g))) u_dut (
         .clk(clk), .reset(reset), .start(start_v[g]), .busy(busy[g]), .done(done[g]),
         .found(found[g]), .overflow(ovf[g]), .start_x(sx[g]), .start_y(sy[g]),
         .code(code[g]), .code_valid(cv[g]), .code_count(ccl));
      assign cc[g] = 9'(ccl);
   end

   function automatic void chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // monitor
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (cv[i] === 1'b1) begin
            if (i != sel) chk("stray_code_valid_dut", i, sel);
            else if (!busy[i]) chk("code_valid_while_idle", 0, 1);
            else if (expq.size() == 0) chk("unexpected_code", int'(code[i]), -1);
            else chk("code", int'(code[i]), int'(expq.pop_front()));
         end
      end
   end

   task automatic run(input int g, output int cyc);
      sel = g;
      start_v[g] = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!done[g] && cyc < 2000);
      if (!done[g]) chk("done_timeout", cyc, -1);
   endtask

   task automatic push4(input logic [2:0] a, b, c, d);
      expq.push_back(a); expq.push_back(b); expq.push_back(c); expq.push_back(d);
   endtask

   int cyc;

   initial begin
      for (int i = 0; i < N; i++) start_v[i] = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy[2], 0);
      chk("rst_done", done[2], 0);
      chk("rst_found", found[2], 0);
      chk("rst_count", cc[2], 0);
      reset = 1'b1;
      @(negedge clk);

      // empty image: one accept cycle plus one per pixel
      run(0, cyc);
      chk("empty_cycles", cyc, 1 + 16*16);
      chk("empty_found", found[0], 0);
      chk("empty_count", cc[0], 0);
      chk("empty_busy", busy[0], 0);
      start_v[0] = 1'b0;

      // isolated pixel: accept + 118 scanned pixels + 8 neighbour tests
      run(1, cyc);
      chk("single_cycles", cyc, 1 + 118 + 8);
      chk("single_found", found[1], 1);
      chk("single_x", sx[1], 5);
      chk("single_y", sy[1], 7);
      chk("single_count", cc[1], 0);
      start_v[1] = 1'b0;

      push4(3'd0, 3'd6, 3'd4, 3'd2);
      run(2, cyc);
      chk("sq_count", cc[2], 4);
      chk("sq_x", sx[2], 3);
      chk("sq_y", sy[2], 2);
      chk("sq_ovf", ovf[2], 0);
      chk("sq_pending", expq.size(), 0);

      // start held: no second run
      repeat (300) @(negedge clk);
      chk("hold_done", done[2], 1);
      chk("hold_count", cc[2], 4);
      start_v[2] = 1'b0;
      @(negedge clk);
      chk("drop_done", done[2], 0);
      push4(3'd0, 3'd6, 3'd4, 3'd2);
      run(2, cyc);
      chk("rerun_count", cc[2], 4);
      chk("rerun_pending", expq.size(), 0);
      start_v[2] = 1'b0;
      @(negedge clk);

      push4(3'd0, 3'd0, 3'd4, 3'd4);
      run(3, cyc);
      chk("line_count", cc[3], 4);
      chk("line_x", sx[3], 0);
      chk("line_y", sy[3], 0);
      chk("line_pending", expq.size(), 0);
      start_v[3] = 1'b0;
      @(negedge clk);

      // reset in the middle of a trace
      expq.push_back(3'd0);
      sel = 2;
      start_v[2] = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (cc[2] != 9'd1 && cyc < 2000);
      chk("mid_reached", cc[2], 1);
      chk("mid_busy", busy[2], 1);
      reset = 1'b0;
      start_v[2] = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy[2], 0);
      chk("abort_done", done[2], 0);
      chk("abort_found", found[2], 0);
      chk("abort_count", cc[2], 0);
      chk("abort_xy", {sx[2], sy[2]}, 0);
      reset = 1'b1;
      @(negedge clk);
      push4(3'd0, 3'd6, 3'd4, 3'd2);
      run(2, cyc);
      chk("after_rst_count", cc[2], 4);
      chk("after_rst_pending", expq.size(), 0);
      start_v[2] = 1'b0;
      @(negedge clk);

      // MAX_CODES=2 cuts the square after two moves
      expq.push_back(3'd0);
      expq.push_back(3'd6);
      run(4, cyc);
      chk("ovf_flag", ovf[4], 1);
      chk("ovf_count", cc[4], 2);
      chk("ovf_found", found[4], 1);
      chk("ovf_pending", expq.size(), 0);
      start_v[4] = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
